// File: rtl/nearest_hit_scheduler.sv
// nearest_hit_scheduler: issues triangle indices for one ray to the
// fetch+intersect pipeline, tracks in-order responses and keeps the nearest hit.
// Optional feature macro: NEAREST_HIT_ANY_HIT_EN (adds the any_hit input for
// shadow rays: stop issuing at the first hit).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// Valid never depends on ready on the same interface; req_idx, ray_out and the
// res_* outputs hold stable while their valid is high and ready is low.
// rsp_valid has no ready: every response pulse is consumed.
module nearest_hit_scheduler #(
    parameter int WIDTH   = 32,
    parameter int TRI_AW  = 10,
    parameter int MAX_OUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ray_valid,
    output logic                 ray_ready,
    input  logic [6*WIDTH-1:0]   ray_in,
    input  logic [TRI_AW:0]      tri_count,
`ifdef NEAREST_HIT_ANY_HIT_EN
    input  logic                 any_hit,
`endif
    output logic [6*WIDTH-1:0]   ray_out,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [TRI_AW-1:0]    req_idx,
    input  logic                 rsp_valid,
    input  logic [1:0]           rsp_code,
    input  logic [WIDTH-1:0]     rsp_t,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_hit,
    output logic [TRI_AW-1:0]    res_idx,
    output logic [WIDTH-1:0]     res_t,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam logic [OW-1:0]     OUT_MAX = OW'(MAX_OUT);
    localparam logic [OW-1:0]     OUT_ONE = OW'(1);
    localparam logic [TRI_AW:0]   IDX_ONE = (TRI_AW + 1)'(1);
    localparam logic [TRI_AW-1:0] RSP_ONE = TRI_AW'(1);
    localparam logic [WIDTH-1:0]  T_MAX   = {1'b0, {(WIDTH - 1){1'b1}}};

    state_t              state, state_nxt;
    logic [TRI_AW:0]     next_idx;
    logic [TRI_AW:0]     count;
    logic [TRI_AW-1:0]   rsp_idx;
    logic [OW-1:0]       outstanding, out_nxt;
    logic [WIDTH-1:0]    best_t;
    logic [TRI_AW-1:0]   best_idx;
    logic                best_valid;
    logic [6*WIDTH-1:0]  ray_q;
    logic                any_hit_q;

    logic accept, rsp_ok, lock, take, fire, last_fire, stop;

    assign accept    = (state == IDLE) && ray_valid;
    // A response with nothing outstanding is a protocol violation and is dropped.
    assign rsp_ok    = rsp_valid && (outstanding != '0);
    // In any-hit mode the first recorded hit freezes the result.
    assign lock      = any_hit_q && best_valid;
    assign take      = rsp_ok && (rsp_code == 2'b10) && !lock &&
                       ($signed(rsp_t) < $signed(best_t));
    assign req_valid = (state == ISSUE) && (next_idx < count) && (outstanding < OUT_MAX);
    assign fire      = req_valid && req_ready;
    assign last_fire = fire && ((next_idx + IDX_ONE) == count);
    assign stop      = any_hit_q && take;

    assign req_idx   = next_idx[TRI_AW-1:0];
    assign ray_out   = ray_q;
    assign res_valid = (state == DONE);
    assign res_hit   = best_valid;
    assign res_t     = best_valid ? best_t : '0;
    assign res_idx   = best_valid ? best_idx : '0;
    assign dbg_state = state;

    // Outstanding count after this cycle's issue and response.
    always_comb begin
        out_nxt = outstanding;
        if (fire && !rsp_ok) begin
            out_nxt = outstanding + OUT_ONE;
        end else if (!fire && rsp_ok) begin
            out_nxt = outstanding - OUT_ONE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE is entered directly once nothing is left in flight.
    always_comb begin
        state_nxt = state;
        ray_ready = 1'b0;
        case (state)
            IDLE: begin
                ray_ready = 1'b1;
                if (ray_valid) begin
                    state_nxt = (tri_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (last_fire || stop) begin
                    state_nxt = (out_nxt == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (out_nxt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ray latch, issue/response counters and nearest-hit tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ray_q       <= '0;
            count       <= '0;
            next_idx    <= '0;
            rsp_idx     <= '0;
            outstanding <= '0;
            best_t      <= '0;
            best_idx    <= '0;
            best_valid  <= 1'b0;
        end else if (accept) begin
            ray_q       <= ray_in;
            count       <= tri_count;
            next_idx    <= '0;
            rsp_idx     <= '0;
            outstanding <= '0;
            best_t      <= T_MAX;
            best_idx    <= '0;
            best_valid  <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            if (fire) begin
                next_idx <= next_idx + IDX_ONE;
            end
            if (rsp_ok) begin
                rsp_idx <= rsp_idx + RSP_ONE;
            end
            if (take) begin
                best_t     <= rsp_t;
                best_idx   <= rsp_idx;
                best_valid <= 1'b1;
            end
        end
    end

`ifdef NEAREST_HIT_ANY_HIT_EN
    // Latch the any-hit mode together with the ray.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_hit_q <= 1'b0;
        end else if (accept) begin
            any_hit_q <= any_hit;
        end
    end
`else
    assign any_hit_q = 1'b0;
`endif

`ifndef SYNTHESIS
    // Responses are only legal while at least one request is in flight.
    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_valid && (outstanding == '0)));
`endif

endmodule

// File: tb/tb_nearest_hit_scheduler.sv
// Testbench for nearest_hit_scheduler: directed vector table, randomized rays
// against a reference model, and hand-written corner sequences.
module tb_nearest_hit_scheduler;

    localparam int WIDTH   = 32;
    localparam int TRI_AW  = 10;
    localparam int MAX_OUT = 8;
    localparam int RW      = 6 * WIDTH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ray_valid = 1'b0;
    logic              ray_ready;
    logic [RW-1:0]     ray_in = '0;
    logic [TRI_AW:0]   tri_count = '0;
`ifdef NEAREST_HIT_ANY_HIT_EN
    logic              any_hit = 1'b0;
`endif
    logic [RW-1:0]     ray_out;
    logic              req_valid;
    logic              req_ready = 1'b0;
    logic [TRI_AW-1:0] req_idx;
    logic              rsp_valid = 1'b0;
    logic [1:0]        rsp_code = '0;
    logic [WIDTH-1:0]  rsp_t = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              res_hit;
    logic [TRI_AW-1:0] res_idx;
    logic [WIDTH-1:0]  res_t;
    logic [1:0]        dbg_state;

    nearest_hit_scheduler #(.WIDTH(WIDTH), .TRI_AW(TRI_AW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_in(ray_in), .tri_count(tri_count),
`ifdef NEAREST_HIT_ANY_HIT_EN
        .any_hit(any_hit),
`endif
        .ray_out(ray_out),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_t(rsp_t),
        .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
        .res_idx(res_idx), .res_t(res_t), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- environment state ----------------
    int         cyc = 0;
    int         lat_cur = 1;
    int         rdy_mode = 1;      // 0: ready low, 1: ready high, 2: random
    bit         hold_rsp = 1'b0;
    int         credit = 0;
    logic [1:0] rc_mem [64];
    logic [31:0] rt_mem [64];
    int         pend_idx[$];
    int         pend_due[$];
    int         log_idx[$];
    int         log_cyc[$];
    int         last_rsp_cyc = -1;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        int          cnt;
        int          lat;
        logic [7:0]  codes;   // code of idx j at [2j +: 2]
        logic [127:0] ts;     // t of idx j at [32j +: 32]
        bit          eh;
        int          ei;
        logic [31:0] et;
    } vec_t;
    vec_t tv [6];

    // Pipeline emulation: ready generation and in-order responses after a fixed latency.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        case (rdy_mode)
            0:       req_ready = 1'b0;
            1:       req_ready = 1'b1;
            default: req_ready = 1'($urandom_range(0, 1));
        endcase
        rsp_valid = 1'b0;
        rsp_code  = 2'($urandom);
        rsp_t     = $urandom;
        if (pend_idx.size() > 0 && pend_due[0] <= cyc && (!hold_rsp || credit > 0)) begin
            if (hold_rsp) credit = credit - 1;
            rsp_valid = 1'b1;
            rsp_code  = rc_mem[pend_idx[0]];
            rsp_t     = rt_mem[pend_idx[0]];
            void'(pend_idx.pop_front());
            void'(pend_due.pop_front());
        end
    end

    // Monitor: log request handshakes and note the last response cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready) begin
                pend_idx.push_back(int'(req_idx));
                pend_due.push_back(cyc + lat_cur);
                log_idx.push_back(int'(req_idx));
                log_cyc.push_back(cyc);
            end
            if (rsp_valid) last_rsp_cyc = cyc;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: nearest hit over the triangle list, earliest index on ties.
    task automatic model(input int cnt, output bit h, output int idx, output logic [31:0] t);
        logic signed [31:0] best;
        best = 32'sh7FFF_FFFF;
        h = 1'b0;
        idx = 0;
        for (int i = 0; i < cnt; i++) begin
            if (rc_mem[i] == 2'b10 && $signed(rt_mem[i]) < best) begin
                best = $signed(rt_mem[i]);
                idx = i;
                h = 1'b1;
            end
        end
        t = h ? 32'(best) : 32'h0;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_ray_ready"}, RW'(ray_ready), RW'(1));
        check({p, "_req_valid"}, RW'(req_valid), RW'(0));
        check({p, "_res_valid"}, RW'(res_valid), RW'(0));
        check({p, "_res_hit"},   RW'(res_hit),   RW'(0));
        check({p, "_req_idx"},   RW'(req_idx),   RW'(0));
        check({p, "_res_idx"},   RW'(res_idx),   RW'(0));
        check({p, "_res_t"},     RW'(res_t),     RW'(0));
        check({p, "_ray_out"},   ray_out,        RW'(0));
    endtask

    task automatic accept_ray(input int cnt, input logic [RW-1:0] ray);
        check("ray_ready_idle", RW'(ray_ready), RW'(1));
        ray_valid = 1'b1;
        ray_in    = ray;
        tri_count = (TRI_AW + 1)'(cnt);
        @(posedge clk); #1;
        ray_valid = 1'b0;
        ray_in    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tri_count = (TRI_AW + 1)'($urandom_range(0, 1024));
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!res_valid && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("res_wait_timeout", RW'(res_valid), RW'(1));
    endtask

    task automatic check_result(input int exp_reqs, input bit eh, input int ei,
                                input logic [31:0] et, input logic [RW-1:0] ray);
        check("res_hit", RW'(res_hit), RW'(eh));
        check("res_idx", RW'(res_idx), RW'(ei));
        check("res_t",   RW'(res_t),   RW'(et));
        check("ray_out", ray_out, ray);
        check("req_count", RW'(log_idx.size()), RW'(exp_reqs));
        for (int i = 0; i < log_idx.size(); i++) begin
            if (log_idx[i] != i) check("req_order", RW'(log_idx[i]), RW'(i));
        end
    endtask

    task automatic finish_result(input int hold, input bit eh, input int ei,
                                 input logic [31:0] et, input logic [RW-1:0] ray);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_res_valid", RW'(res_valid), RW'(1));
            check("hold_res_hit",   RW'(res_hit),   RW'(eh));
            check("hold_res_idx",   RW'(res_idx),   RW'(ei));
            check("hold_res_t",     RW'(res_t),     RW'(et));
            check("hold_ray_ready", RW'(ray_ready), RW'(0));
            check("hold_ray_out",   ray_out,        ray);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("post_res_ray_ready", RW'(ray_ready), RW'(1));
        check("post_res_valid",     RW'(res_valid), RW'(0));
        check("no_stale_rsp",       RW'(pend_idx.size()), RW'(0));
    endtask

    // One complete ray with the response data already loaded into rc_mem/rt_mem.
    task automatic run_ray(input int cnt, input int lat, input int mode, input int exp_reqs,
                           input bit eh, input int ei, input logic [31:0] et, input int hold);
        logic [RW-1:0] ray;
        ray = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        lat_cur = lat;
        rdy_mode = mode;
        log_idx.delete();
        log_cyc.delete();
        last_rsp_cyc = -1;
        accept_ray(cnt, ray);
        if (cnt == 0) begin
            check("zero_res_valid_n1", RW'(res_valid), RW'(1));
            check("zero_req_valid",    RW'(req_valid), RW'(0));
        end else begin
            check("req_valid_n1", RW'(req_valid), RW'(1));
        end
        wait_result();
        if (cnt > 0) check("res_latency", RW'(cyc), RW'(last_rsp_cyc + 1));
        check_result(exp_reqs, eh, ei, et, ray);
        finish_result(hold, eh, ei, et, ray);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit          mh;
        int          mi;
        logic [31:0] mt;
        int          cnt;
        int          n;
        logic [RW-1:0] ray;

        tv[0] = '{4, 3, {2'b10, 2'b10, 2'b10, 2'b00},
                  {32'h0000_8000, 32'h0000_8000, 32'h0001_8000, 32'h0}, 1'b1, 2, 32'h0000_8000};
        tv[1] = '{0, 1, 8'h00, 128'h0, 1'b0, 0, 32'h0};
        tv[2] = '{3, 2, {2'b00, 2'b11, 2'b00, 2'b01},
                  {32'h0, 32'h7, 32'h6, 32'h5}, 1'b0, 0, 32'h0};
        tv[3] = '{1, 1, {2'b00, 2'b00, 2'b00, 2'b10},
                  {32'h0, 32'h0, 32'h0, 32'h7FFF_FFFE}, 1'b1, 0, 32'h7FFF_FFFE};
        tv[4] = '{4, 4, {2'b10, 2'b01, 2'b00, 2'b10},
                  {32'h300, 32'h0, 32'h0, 32'h300}, 1'b1, 0, 32'h300};
        tv[5] = '{2, 5, {2'b00, 2'b00, 2'b10, 2'b01},
                  {32'h0, 32'h0, 32'h1, 32'h0}, 1'b1, 1, 32'h1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        check("reset_dbg_state", RW'(dbg_state), RW'(0));
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table; the first entry also holds the result for 5 cycles.
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) begin
                rc_mem[j] = tv[i].codes[2*j +: 2];
                rt_mem[j] = tv[i].ts[32*j +: 32];
            end
            run_ray(tv[i].cnt, tv[i].lat, 1, tv[i].cnt, tv[i].eh, tv[i].ei, tv[i].et,
                    (i == 0) ? 5 : 1);
        end

        // Randomized rays against the reference model.
        for (int r = 0; r < 12; r++) begin
            cnt = $urandom_range(1, 40);
            for (int j = 0; j < cnt; j++) begin
                rc_mem[j] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 3));
                rt_mem[j] = 32'($urandom_range(1, 16)) << 12;
            end
            model(cnt, mh, mi, mt);
            run_ray(cnt, $urandom_range(1, 6), (r % 3 == 0) ? 1 : 2, cnt, mh, mi, mt,
                    $urandom_range(0, 2));
        end

        // Backpressure and outstanding limit: 20 triangles, responses withheld.
        cnt = 20;
        for (int j = 0; j < cnt; j++) begin
            rc_mem[j] = 2'($urandom_range(0, 3));
            rt_mem[j] = 32'($urandom_range(1, 16)) << 12;
        end
        model(cnt, mh, mi, mt);
        hold_rsp = 1'b1;
        credit = 0;
        lat_cur = 1;
        rdy_mode = 1;
        log_idx.delete();
        log_cyc.delete();
        ray = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        accept_ray(cnt, ray);
        repeat (15) @(posedge clk);
        #1;
        check("bp_max_out_reqs", RW'(log_idx.size()), RW'(MAX_OUT));
        check("bp_req_valid_low", RW'(req_valid), RW'(0));
        for (int k = 0; k < 3; k++) begin
            credit = 1;
            repeat (4) @(posedge clk);
            #1;
            check("bp_one_more_req", RW'(log_idx.size()), RW'(MAX_OUT + 1 + k));
            check("bp_req_valid_low2", RW'(req_valid), RW'(0));
        end
        rdy_mode = 0;
        credit = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("stall_req_valid", RW'(req_valid), RW'(1));
            check("stall_req_idx",   RW'(req_idx),   RW'(MAX_OUT + 3));
            @(posedge clk); #1;
        end
        hold_rsp = 1'b0;
        rdy_mode = 2;
        wait_result();
        check_result(cnt, mh, mi, mt, ray);
        finish_result(1, mh, mi, mt, ray);

        // Reset mid-operation: DRAIN with 3 responses in flight.
        cnt = 10;
        for (int j = 0; j < cnt; j++) begin
            rc_mem[j] = 2'b10;
            rt_mem[j] = 32'h1000;
        end
        lat_cur = 3;
        rdy_mode = 1;
        log_idx.delete();
        log_cyc.delete();
        ray = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        accept_ray(cnt, ray);
        n = 0;
        while (log_idx.size() < cnt && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_all_issued", RW'(log_idx.size()), RW'(cnt));
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        pend_idx.delete();
        pend_due.delete();
        rsp_valid = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 5; j++) begin
            rc_mem[j] = 2'b10;
            rt_mem[j] = 32'(5 - j) << 8;
        end
        run_ray(5, 2, 1, 5, 1'b1, 4, 32'h100, 1);

`ifdef NEAREST_HIT_ANY_HIT_EN
        // Any-hit: idx1 hits first; the request issued in that same cycle (idx4)
        // is the last one, later hits do not change the result.
        cnt = 10;
        for (int j = 0; j < cnt; j++) begin
            rc_mem[j] = 2'b00;
            rt_mem[j] = 32'h0;
        end
        rc_mem[1] = 2'b10; rt_mem[1] = 32'h0001_0000;
        rc_mem[3] = 2'b10; rt_mem[3] = 32'h0000_4000;
        any_hit = 1'b1;
        run_ray(cnt, 3, 1, 5, 1'b1, 1, 32'h0001_0000, 1);
        for (int i = 0; i < log_cyc.size(); i++) begin
            if (log_cyc[i] > log_cyc[1] + 3) check("anyhit_late_req", RW'(log_cyc[i]), RW'(log_cyc[1] + 3));
        end
        any_hit = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/nearest_hit_scheduler.md
# nearest_hit_scheduler

Sequences the ray/triangle intersection datapath for one ray at a time. It accepts a ray and a triangle count, then issues triangle indices to the external fetch+intersect pipeline under a bounded-outstanding handshake. It collects the in-order hit responses, keeps the nearest positive `t`, and reports the closest triangle. It sits between the ray generator / reflection-refraction stage and the intersection unit.

## Interface
- `WIDTH`, default 32: fixed-point word width; must equal `_WIDTH` from `definitions_pack`.
- `TRI_AW`, default 10: triangle index width.
- `MAX_OUT`, default 8: maximum outstanding intersection requests; power of two, at least 2.

Ports (clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ray_valid` in 1: ray request valid.
- `ray_ready` out 1: scheduler idle and able to accept a ray.
- `ray_in` in 6*WIDTH: ray (start, dir), packed as type `ray`.
- `tri_count` in TRI_AW+1: number of triangles to test, 0..2^TRI_AW.
- `ray_out` out 6*WIDTH: registered copy of the accepted ray, stable from accept until result handshake.
- `req_valid` out 1: intersection request valid.
- `req_ready` in 1: pipeline accepts the request.
- `req_idx` out TRI_AW: triangle index to fetch and test.
- `rsp_valid` in 1: intersection result valid; no backpressure.
- `rsp_code` in 2: result code; `2'b10` means hit, anything else means miss.
- `rsp_t` in WIDTH: signed fixed-point distance; meaningful only on hit.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes the result.
- `res_hit` out 1: at least one hit.
- `res_idx` out TRI_AW: index of the nearest hit.
- `res_t` out WIDTH: `t` of the nearest hit.

## Operation
FSM states are IDLE, ISSUE, DRAIN and DONE.

- **IDLE**
  - `ray_ready`=1.
  - On `ray_valid`:
    - latch `ray_in` and `tri_count`;
    - clear `next_idx`, `outstanding`, `best_valid`;
    - set `best_t` to the max positive value (`0x7FF..F`).
  - Go to ISSUE, or to DONE when `tri_count`==0.
- **ISSUE**
  - `req_valid` = (`next_idx` < count) && (`outstanding` < MAX_OUT).
  - `req_idx` = `next_idx`.
  - On `req_valid && req_ready`: `next_idx`++ and `outstanding`++.
  - When the final request handshakes, go to DRAIN.
- **DRAIN**
  - `req_valid`=0.
  - When `outstanding` reaches 0, with no response pending, go to DONE.
- **DONE**
  - `res_valid`=1; outputs hold stable.
  - On `res_ready`, go to IDLE.
- **Response tracking**
  - Responses arrive in issue order.
  - A separate `rsp_idx` counter tracks the index of each response.
  - Any `rsp_valid` decrements `outstanding`.
  - If the response is a hit with `rsp_t` < `best_t` (signed compare), update `best_t`, set `res_idx`=`rsp_idx`, and set `best_valid`=1.
  - Equal `t` keeps the earlier (lower) index.
- **Outputs**
  - `res_hit`=`best_valid`.
  - `res_t`=`best_t` when hit, 0 otherwise.
  - `res_idx`=0 when no hit.
- **Issue and response in the same cycle:** `outstanding` is unchanged.
- **Protocol violation:** `rsp_valid` while `outstanding`==0 is ignored (no state change) and fires a simulation assertion.

## Timing
- Reset values:
  - state = IDLE;
  - `ray_ready`=1;
  - `req_valid`=0;
  - `res_valid`=0, `res_hit`=0;
  - `req_idx`=0, `res_idx`=0, `res_t`=0, `ray_out`=0;
  - all counters = 0.
- Ray accept at cycle N: `req_valid` can be high at N+1.
- Peak throughput is 1 request per cycle while `outstanding` < MAX_OUT.
- A request held with `req_ready`=0 keeps `req_idx` stable.
- Last response at cycle M: `res_valid` rises at M+1.
- `tri_count`=0 accepted at N: `res_valid`=1 at N+1 with `res_hit`=0.
- `res_valid && res_ready` at cycle K: `ray_ready`=1 at K+1. No new ray is accepted in the same cycle.
- `rst_n` low mid-operation clears everything immediately. In-flight responses arriving after reset are protocol violations and are ignored.

## Configuration
- `NEAREST_HIT_ANY_HIT_EN`
  - **Defined:** adds input port `any_hit` (1 bit), latched at ray accept.
    - When the latched `any_hit`=1, the first hit response updates the best entry and stops further issue (ISSUE goes to DRAIN).
    - Remaining responses are drained but do not update the result.
    - Used for shadow rays.
  - **Undefined:** the port is absent and every triangle is always tested.

## Test plan
- **Nearest of three hits:** `tri_count`=4, `req_ready`=1, latency 3; responses miss, hit t=0x00018000, hit t=0x00008000, hit t=0x00008000. Expect `res_hit`=1, `res_idx`=2, `res_t`=0x00008000, and exactly 4 requests with idx 0..3.
- **Zero triangles:** `tri_count`=0. Expect no `req_valid`, and `res_valid` one cycle after accept with `res_hit`=0, `res_idx`=0, `res_t`=0.
- **Backpressure and outstanding limit:** MAX_OUT=8, `tri_count`=20, responses withheld. Expect exactly 8 requests, then `req_valid`=0. After each single response, exactly one more request issues. `req_idx` stays stable while `req_ready`=0.
- **Reset mid-operation:** assert `rst_n`=0 during DRAIN with 3 outstanding. Outputs go to reset values immediately. A new ray after release completes normally with idx restarting at 0.
- **Any-hit mode (macro defined, `any_hit`=1):** `tri_count`=10; idx 1 hits at t=0x00010000 and idx 3 hits at t=0x00004000. Issue stops after idx 1's response. Result is `res_idx`=1, `res_t`=0x00010000.
- **Result hold:** `res_ready`=0 for 5 cycles. Outputs stay constant, `ray_ready`=0 and `ray_out` is unchanged. The cycle after the handshake, `ray_ready`=1.
